vect_addr_gen: RTL and testbench

Parametrised successor to the single-counter vector auto-increment unit in the CGRA vector path. Generates per-element register-file and HBM addresses for vle32/vse32-style vector instructions. Read and write streams have independent counters, so loads and stores progress at different rates. Supports a programmable HBM byte stride and a start/busy/done handshake. Sits between the CGRA decode/issue stage and the RF/HBM AXI request logic.

---
 rtl/vect_addr_gen.sv | 110 +++++++++++
 tb/tb_vect_addr_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vect_addr_gen.sv
// vect_addr_gen: per-element RF/HBM address generator with independent read/write streams; VECT_ADDR_GEN_PERF_EN adds stall_cycles
module vect_addr_gen #(
  parameter int RFADD_W  = 6,
  parameter int INT_W    = 32,
  parameter int HBMADD_W = 33,
  parameter int STRIDE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RFADD_W:0]    itr,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [RFADD_W-1:0]  vr_base,
  input  logic [RFADD_W-1:0]  vw_base,
  input  logic [INT_W-1:0]    base,
  input  logic                abort,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [RFADD_W-1:0]  vr_addr_auto_incr,
  output logic [RFADD_W-1:0]  vw_addr_auto_incr,
  output logic [HBMADD_W-1:0] araddr_HBM,
  output logic [HBMADD_W-1:0] awaddr_HBM,
  output logic                busy,
  output logic                done,
  output logic [RFADD_W:0]    rd_idx,
`ifdef VECT_ADDR_GEN_PERF_EN
  output logic [RFADD_W:0]    wr_idx,
  output logic [31:0]         stall_cycles
`else
  output logic [RFADD_W:0]    wr_idx
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  logic [1:0]          r_state;
  logic [RFADD_W:0]    r_itr, r_rd_idx, r_wr_idx;
  logic [STRIDE_W-1:0] r_stride;
  logic [RFADD_W-1:0]  r_vr_base, r_vw_base;
  logic [HBMADD_W-1:0] r_ar, r_aw;
  logic                w_go, w_rd_hs, w_wr_hs, w_all;
  logic [RFADD_W:0]    w_rd_nxt, w_wr_nxt;
  assign w_go     = start && r_state == IDLE;
  assign rd_valid = r_state == RUN && r_rd_idx < r_itr;
  assign wr_valid = r_state == RUN && r_wr_idx < r_itr;
  assign w_rd_hs  = rd_valid && rd_ready;
  assign w_wr_hs  = wr_valid && wr_ready;
  assign w_rd_nxt = r_rd_idx + (RFADD_W+1)'(w_rd_hs);
  assign w_wr_nxt = r_wr_idx + (RFADD_W+1)'(w_wr_hs);
  assign w_all    = w_rd_nxt == r_itr && w_wr_nxt == r_itr;
  assign vr_addr_auto_incr = r_vr_base + r_rd_idx[RFADD_W-1:0];
  assign vw_addr_auto_incr = r_vw_base + r_wr_idx[RFADD_W-1:0];
  assign araddr_HBM = r_ar;
  assign awaddr_HBM = r_aw;
  assign busy   = r_state == RUN;
  assign done   = r_state == FIN;
  assign rd_idx = r_rd_idx;
  assign wr_idx = r_wr_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_itr     <= '0;
      r_stride  <= '0;
      r_vr_base <= '0;
      r_vw_base <= '0;
      r_rd_idx  <= '0;
      r_wr_idx  <= '0;
      r_ar      <= '0;
      r_aw      <= '0;
    end else begin
      r_state <= w_go ? (itr == '0 ? FIN : RUN) :
                 r_state == RUN ? (abort || w_all ? FIN : RUN) :
                 r_state == FIN ? IDLE : r_state;
      if (w_go) begin
        r_itr     <= itr;
        r_stride  <= stride;
        r_vr_base <= vr_base;
        r_vw_base <= vw_base;
        r_ar      <= HBMADD_W'(base);
        r_aw      <= HBMADD_W'(base);
      end
      if (r_state == RUN && !abort) begin
        if (w_rd_hs) begin
          r_rd_idx <= w_rd_nxt;
          r_ar     <= r_ar + HBMADD_W'(r_stride);
        end
        if (w_wr_hs) begin
          r_wr_idx <= w_wr_nxt;
          r_aw     <= r_aw + HBMADD_W'(r_stride);
        end
      end
      if (r_state == FIN) begin
        r_rd_idx <= '0;
        r_wr_idx <= '0;
      end
    end
  end
`ifdef VECT_ADDR_GEN_PERF_EN
  logic [31:0] r_stall;
  logic        w_stall;
  assign w_stall      = r_state == RUN && ((rd_valid && !rd_ready) || (wr_valid && !wr_ready));
  assign stall_cycles = r_stall;
  always_ff @(posedge clk) begin
    if (rst || w_go) r_stall <= '0;
    else if (w_stall && r_stall != '1) r_stall <= r_stall + 32'd1;
  end
`endif
endmodule

// File: tb/tb_vect_addr_gen.sv
// tb_vect_addr_gen: scoreboard bench for vect_addr_gen, default widths plus a HBMADD_W=32 instance
module tb_vect_addr_gen;
  logic        clk = 0, rst = 1, start = 0, abort = 0, rd_ready = 1, wr_ready = 1;
  logic [6:0]  itr = '0;
  logic [15:0] stride = '0;
  logic [5:0]  vr_base = '0, vw_base = '0;
  logic [31:0] base = '0;
  logic        rd_valid, wr_valid, busy, done;
  logic [5:0]  vr_addr, vw_addr;
  logic [32:0] araddr, awaddr;
  logic [6:0]  rd_idx, wr_idx;
  logic        rd_valid2, wr_valid2, busy2, done2;
  logic [5:0]  vr_addr2, vw_addr2;
  logic [31:0] araddr2, awaddr2;
  logic [6:0]  rd_idx2, wr_idx2;
`ifdef VECT_ADDR_GEN_PERF_EN
  logic [31:0] stall_cycles, stall_cycles2;
`endif
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic [5:0]  rf;
    logic [32:0] a;
    logic [31:0] a32;
  } exp_t;
  exp_t rq[$], wq[$];
  always #5 clk = ~clk;
  vect_addr_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .itr(itr), .stride(stride), .vr_base(vr_base),
    .vw_base(vw_base), .base(base), .abort(abort), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .vr_addr_auto_incr(vr_addr),
    .vw_addr_auto_incr(vw_addr), .araddr_HBM(araddr), .awaddr_HBM(awaddr), .busy(busy),
    .done(done), .rd_idx(rd_idx),
`ifdef VECT_ADDR_GEN_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .wr_idx(wr_idx)
  );
  vect_addr_gen #(.HBMADD_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .itr(itr), .stride(stride), .vr_base(vr_base),
    .vw_base(vw_base), .base(base), .abort(abort), .rd_valid(rd_valid2), .rd_ready(rd_ready),
    .wr_valid(wr_valid2), .wr_ready(wr_ready), .vr_addr_auto_incr(vr_addr2),
    .vw_addr_auto_incr(vw_addr2), .araddr_HBM(araddr2), .awaddr_HBM(awaddr2), .busy(busy2),
    .done(done2), .rd_idx(rd_idx2),
`ifdef VECT_ADDR_GEN_PERF_EN
    .stall_cycles(stall_cycles2),
`endif
    .wr_idx(wr_idx2)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (rq.size() == 0) chk("rd_unexp", 1, 0);
        else begin
          chk("vr_addr", vr_addr, rq[0].rf);
          chk("araddr", araddr, rq[0].a);
          chk("araddr32", araddr2, rq[0].a32);
          if (rd_ready && !abort) void'(rq.pop_front());
        end
      end
      if (wr_valid) begin
        if (wq.size() == 0) chk("wr_unexp", 1, 0);
        else begin
          chk("vw_addr", vw_addr, wq[0].rf);
          chk("awaddr", awaddr, wq[0].a);
          chk("awaddr32", awaddr2, wq[0].a32);
          if (wr_ready && !abort) void'(wq.pop_front());
        end
      end
    end
  end
  task automatic push(input int n, input longint st, input longint b, input int vrb, input int vwb);
    exp_t e;
    logic [63:0] t;
    for (int k = 0; k < n; k++) begin
      t     = 64'(b + longint'(k) * st);
      e.a   = t[32:0];
      e.a32 = t[31:0];
      e.rf  = 6'(vrb + k);
      rq.push_back(e);
      e.rf  = 6'(vwb + k);
      wq.push_back(e);
    end
  endtask
  task automatic kick(input int n, input longint st, input longint b, input int vrb, input int vwb);
    push(n, st, b, vrb, vwb);
    start = 1; itr = 7'(n); stride = 16'(st); base = 32'(b); vr_base = 6'(vrb); vw_base = 6'(vwb);
    rd_ready = 1; wr_ready = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic run(input int n, input longint st, input longint b, input int vrb, input int vwb,
                     input int pat, input int ab_cyc, input int st_cyc, input int exp_done, input int exp_fin);
    int cyc = 0;
    bit fin = 0;
    kick(n, st, b, vrb, vwb);
    while (!fin) begin
      cyc++;
      rd_ready = 1;
      wr_ready = pat == 1 ? cyc % 2 == 0 : pat == 2 ? !(cyc >= 2 && cyc <= 4) : 1'b1;
      abort = cyc == ab_cyc;
      start = cyc == st_cyc;
      if (cyc == st_cyc) begin
        itr = 7'd1; base = 32'hdead0000; stride = 16'd3; vr_base = 6'd7; vw_base = 6'd9;
      end
      @(negedge clk);
      chk("busy", busy, n != 0 && cyc < exp_done);
      chk("done", done, cyc == exp_done);
      fin = done || cyc >= exp_done;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    chk("rd_idx_fin", rd_idx, exp_fin);
    chk("wr_idx_fin", wr_idx, exp_fin);
    @(posedge clk); #1 abort = 0; start = 0;
    @(negedge clk);
    chk("done_clr", done, 0);
    chk("rd_idx_idle", rd_idx, 0);
    chk("wr_idx_idle", wr_idx, 0);
    chk("rd_left", rq.size(), n - exp_fin);
    chk("wr_left", wq.size(), n - exp_fin);
    rq.delete();
    wq.delete();
    @(posedge clk); #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_vr_addr", vr_addr, 0);
    chk("rst_vw_addr", vw_addr, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_wr_idx", wr_idx, 0);
    @(posedge clk); #1;
    run(4, 4, 'h1000, 2, 10, 0, 0, 0, 5, 4);
    run(4, 4, 'h1000, 2, 10, 1, 0, 0, 9, 4);
    run(0, 4, 'h1000, 2, 10, 0, 0, 0, 1, 0);
    run(4, 8, 'hFFFFFFFC, 62, 0, 0, 0, 0, 5, 4);
    run(8, 1, 'h20, 0, 0, 0, 3, 2, 4, 2);
    run(64, 2, 'h0, 5, 33, 0, 0, 0, 65, 64);
    run(4, 16, 'h4000, 1, 3, 2, 0, 0, 8, 4);
`ifdef VECT_ADDR_GEN_PERF_EN
    chk("stall_cycles", stall_cycles, 3);
`endif
    kick(8, 4, 'h8000, 3, 4);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1 rst = 0;
    rq.delete();
    wq.delete();
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_vw_addr", vw_addr, 0);
    chk("mid_rst_rd_idx", rd_idx, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_done", done, 0);
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
